// File: rtl/av_write_responder.sv
// Avalon-MM write-only slave buffering {address, data} into a FWFT FIFO sink.
// Optional address-window filtering enabled by defining AV_ADDR_FILTER_EN.
module av_write_responder #(
  parameter int          DEPTH     = 8,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] SPAN      = 16'h0100
) (
  input  logic                     sysclk,
  input  logic                     sysreset_n,
  input  logic [15:0]              av_address,
  input  logic [15:0]              av_writedata,
  input  logic                     av_write,
  output logic                     av_waitrequest,
  output logic [15:0]              sink_address,
  output logic [15:0]              sink_data,
  output logic                     sink_valid,
  input  logic                     sink_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] cnt;
  logic [LW-1:0] cnt_nx;
  logic          full_q;
  logic          init_q;
  logic          valid_q;
  logic          accept;
  logic          keep;
  logic          push;
  logic          pop;
  logic [31:0]   mem [DEPTH];

  // Reset pin is ORed in so the master is stalled while reset is asserted.
  assign av_waitrequest = full_q | init_q | ~sysreset_n;
  assign accept = av_write & ~av_waitrequest;
  assign pop    = valid_q & sink_ready;
  assign push   = accept & keep;

`ifdef AV_ADDR_FILTER_EN
  logic [16:0] addr_x;
  logic [16:0] lo_x;
  logic [16:0] hi_x;
  logic [15:0] drop_q;

  // 17-bit window so BASE_ADDR+SPAN may reach 16'h10000.
  assign addr_x = {1'b0, av_address};
  assign lo_x   = {1'b0, BASE_ADDR};
  assign hi_x   = {1'b0, BASE_ADDR} + {1'b0, SPAN};
  assign keep   = (addr_x >= lo_x) && (addr_x < hi_x);

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      drop_q <= '0;
    end else if (accept && !keep && drop_q != 16'hFFFF) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_count = drop_q;
`else
  logic unused_cfg;

  assign keep       = 1'b1;
  assign drop_count = 16'h0000;
  assign unused_cfg = ^{BASE_ADDR, SPAN};
`endif

  always_comb begin
    cnt_nx = cnt;
    case ({push, pop})
      2'b10:   cnt_nx = cnt + LW'(1);
      2'b01:   cnt_nx = cnt - LW'(1);
      default: cnt_nx = cnt;
    endcase
  end

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      full_q  <= 1'b0;
      init_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      init_q  <= 1'b0;
      cnt     <= cnt_nx;
      full_q  <= (cnt_nx == LW'(DEPTH));
      valid_q <= (cnt_nx != '0);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge sysclk) begin
    if (push) begin
      mem[wr_ptr] <= {av_address, av_writedata};
    end
  end

  assign sink_address = mem[rd_ptr][31:16];
  assign sink_data    = mem[rd_ptr][15:0];
  assign sink_valid   = valid_q;
  assign level        = cnt;

endmodule
